sr_latch_seq: RTL and testbench

//  Sequencer/arbiter for a bank of gated SR latches. Accepts set/clear requests from NREQ

---
 rtl/sr_latch_pkg.sv | 26 ++
 rtl/sr_latch_seq_rr_arbiter.sv | 34 +++
 rtl/sr_latch_seq.sv | 181 ++++++++++++++++++
 tb/tb_sr_latch_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared encodings for the SR-latch bank sequencer: latch drive codes, op codes, FSM states.
package sr_latch_pkg;

  localparam logic [1:0] SR_HOLD = 2'b11;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_CLR  = 2'b01;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sr_latch_seq_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer, wrapping.
module rr_arbiter
  import sr_latch_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = PW'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/sr_latch_seq.sv
// Sequencer for a bank of gated SR latches: round-robin grants, timed setup/pulse/hold drive,
// and a shadow copy of each latch value.
module sr_latch_seq
  import sr_latch_pkg::*;
#(
  parameter  int unsigned NREQ      = 4,
  parameter  int unsigned NLAT      = 8,
  parameter  int unsigned SETUP_CYC = 1,
  parameter  int unsigned PULSE_CYC = 2,
  parameter  int unsigned HOLD_CYC  = 1,
  localparam int unsigned IDXW      = (NLAT > 1) ? $clog2(NLAT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [NLAT-1:0]      lat_s,
  output logic [NLAT-1:0]      lat_r,
  output logic [NLAT-1:0]      lat_en,
  output logic [NLAT-1:0]      shadow
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0] SETUP_L = CW'(SETUP_CYC);
  localparam logic [CW-1:0] PULSE_L = CW'(PULSE_CYC);
  localparam logic [CW-1:0] HOLD_L  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] ONE_L   = CW'(1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            op_q, bad_q;
  logic [IDXW-1:0] idx_q;
  logic [NREQ-1:0] gnt_q, ack_q;
  logic            err_q, busy_q;
  logic [NLAT-1:0] s_q, r_q, en_q, shadow_q, shadow_d;
  logic [NLAT-1:0] grant_s_d, grant_r_d, grant_mask, cur_mask;

  logic [NREQ-1:0] arb_grant;
  logic [PW-1:0]   arb_idx;
  logic            arb_valid;
  logic            win_op;
  logic [IDXW-1:0] win_idx;
  logic            win_bad;
  logic [1:0]      win_sr;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Out-of-range indices match no bit, so the mask is empty and the bank is left alone.
  function automatic logic [NLAT-1:0] sel_mask(input logic [IDXW-1:0] idx);
    logic [NLAT-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NLAT; i++) begin
      if (idx == IDXW'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    win_op     = req_op[arb_idx];
    win_idx    = req_idx[32'(arb_idx) * IDXW +: IDXW];
    win_bad    = (32'(win_idx) >= NLAT);
    win_sr     = (win_op == OP_SET) ? SR_SET : SR_CLR;
    grant_mask = sel_mask(win_idx);
    grant_s_d  = '1;
    grant_r_d  = '1;
    for (int unsigned i = 0; i < NLAT; i++) begin
      {grant_s_d[i], grant_r_d[i]} = grant_mask[i] ? win_sr : SR_HOLD;
    end
    ptr_d    = PW'((32'(arb_idx) + 1) % NREQ);
    cur_mask = sel_mask(idx_q);
    shadow_d = (shadow_q & ~cur_mask) | (op_q ? cur_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      op_q     <= 1'b0;
      bad_q    <= 1'b0;
      idx_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      s_q      <= '1;
      r_q      <= '1;
      en_q     <= '0;
      shadow_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            op_q   <= win_op;
            idx_q  <= win_idx;
            bad_q  <= win_bad;
            gnt_q  <= arb_grant;
            ptr_q  <= ptr_d;
            busy_q <= 1'b1;
            s_q    <= grant_s_d;
            r_q    <= grant_r_d;
            if (SETUP_CYC != 0) begin
              state_q <= ST_SETUP;
              cnt_q   <= SETUP_L;
            end else begin
              state_q <= ST_PULSE;
              cnt_q   <= PULSE_L;
              en_q    <= grant_mask;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_q == ONE_L) begin
            state_q <= ST_PULSE;
            cnt_q   <= PULSE_L;
            en_q    <= cur_mask;
          end else begin
            cnt_q <= cnt_q - ONE_L;
          end
        end
        ST_PULSE: begin
          if (cnt_q == ONE_L) begin
            shadow_q <= shadow_d;
            en_q     <= '0;
            if (HOLD_CYC != 0) begin
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_L;
            end else begin
              state_q <= ST_DONE;
              s_q     <= '1;
              r_q     <= '1;
              ack_q   <= gnt_q;
              err_q   <= bad_q;
            end
          end else begin
            cnt_q <= cnt_q - ONE_L;
          end
        end
        ST_HOLD: begin
          if (cnt_q == ONE_L) begin
            state_q <= ST_DONE;
            s_q     <= '1;
            r_q     <= '1;
            ack_q   <= gnt_q;
            err_q   <= bad_q;
          end else begin
            cnt_q <= cnt_q - ONE_L;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign lat_s  = s_q;
  assign lat_r  = r_q;
  assign lat_en = en_q;
  assign shadow = shadow_q;

endmodule

// File: tb/tb_sr_latch_seq.sv
// Directed bench for sr_latch_seq: an 8-latch and a 6-latch instance, acks checked against
// a queue of expected {ack, err, shadow} entries pushed as each request is raised.
module tb_sr_latch_seq;

  logic clk;
  logic rst;

  logic [3:0]  req_a, op_a, ack_a;
  logic [11:0] idx_a;
  logic        err_a, busy_a;
  logic [7:0]  s_a, r_a, en_a, sh_a, zsr_a;

  logic [3:0]  req_b, op_b, ack_b;
  logic [11:0] idx_b;
  logic        err_b, busy_b;
  logic [5:0]  s_b, r_b, en_b, sh_b, zsr_b;

  typedef struct packed {
    logic [3:0] ack;
    logic       err;
    logic [7:0] shadow;
  } sb_t;

  sb_t q_a[$];
  sb_t q_b[$];
  sb_t ea, eb;
  int  n_cmp  = 0;
  int  n_fail = 0;

  sr_latch_seq #(.NREQ(4), .NLAT(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_op(op_a), .req_idx(idx_a),
    .ack(ack_a), .err(err_a), .busy(busy_a),
    .lat_s(s_a), .lat_r(r_a), .lat_en(en_a), .shadow(sh_a)
  );

  sr_latch_seq #(.NREQ(4), .NLAT(6), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_op(op_b), .req_idx(idx_b),
    .ack(ack_b), .err(err_b), .busy(busy_b),
    .lat_s(s_b), .lat_r(r_b), .lat_en(en_b), .shadow(sh_b)
  );

  assign zsr_a = ~(s_a | r_a);
  assign zsr_b = ~(s_b | r_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_a(input int r, input bit op, input int idx);
    req_a[r]         = 1'b1;
    op_a[r]          = op;
    idx_a[r*3 +: 3]  = 3'(idx);
  endtask

  task automatic drive_b(input int r, input bit op, input int idx);
    req_b[r]         = 1'b1;
    op_b[r]          = op;
    idx_b[r*3 +: 3]  = 3'(idx);
  endtask

  // Scoreboard side: every ack pops one expectation; also watch for forbidden {s,r}=00.
  initial begin
    forever begin
      @(negedge clk);
      chk("no_sr00_a", zsr_a, 0);
      chk("no_sr00_b", zsr_b, 0);
      chk("err_alone_a", (err_a && ack_a == 4'b0), 0);
      chk("err_alone_b", (err_b && ack_b == 4'b0), 0);
      if (ack_a !== 4'b0) begin
        if (q_a.size() == 0) chk("unexpected_ack_a", ack_a, 0);
        else begin
          ea = q_a.pop_front();
          chk("sb_ack_a", ack_a, ea.ack);
          chk("sb_err_a", err_a, ea.err);
          chk("sb_shadow_a", sh_a, ea.shadow);
        end
      end
      if (ack_b !== 4'b0) begin
        if (q_b.size() == 0) chk("unexpected_ack_b", ack_b, 0);
        else begin
          eb = q_b.pop_front();
          chk("sb_ack_b", ack_b, eb.ack);
          chk("sb_err_b", err_b, eb.err);
          chk("sb_shadow_b", sh_b, eb.shadow[5:0]);
        end
      end
    end
  end

  initial begin
    int got[$];
    int exp_ord[5];
    int seen;
    bit rer;
    bit found;
    exp_ord = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    req_a = '0; op_a = '0; idx_a = '0;
    req_b = '0; op_b = '0; idx_b = '0;

    // T1 reset
    repeat (2) @(posedge clk);
    tick();
    chk("rst_s_a", s_a, 8'hFF);
    chk("rst_r_a", r_a, 8'hFF);
    chk("rst_en_a", en_a, 8'h00);
    chk("rst_shadow_a", sh_a, 8'h00);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_s_b", s_b, 6'h3F);
    chk("rst_r_b", r_b, 6'h3F);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    tick();

    // T5 on the 6-latch instance: one good set, then an out-of-range index
    drive_b(0, 1'b1, 5);
    q_b.push_back(sb_t'{4'b0001, 1'b0, 8'h20});
    repeat (5) tick();
    chk("b_set_ack", ack_b, 4'b0001);
    chk("b_set_shadow", sh_b, 6'h20);
    req_b = '0;
    tick();
    drive_b(1, 1'b1, 7);
    q_b.push_back(sb_t'{4'b0010, 1'b1, 8'h20});
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("bad_s_b", s_b, 6'h3F);
      chk("bad_r_b", r_b, 6'h3F);
      chk("bad_en_b", en_b, 6'h00);
      chk("bad_shadow_b", sh_b, 6'h20);
    end
    chk("bad_ack_b", ack_b, 4'b0010);
    chk("bad_err_b", err_b, 1);
    req_b = '0;
    tick();

    // T2 single set, req0 idx3; op/idx changes after grant must be ignored
    drive_a(0, 1'b1, 3);
    q_a.push_back(sb_t'{4'b0001, 1'b0, 8'h08});
    tick();
    chk("t2_setup_s", s_a, 8'hFF);
    chk("t2_setup_r", r_a, 8'hF7);
    chk("t2_setup_en", en_a, 8'h00);
    chk("t2_busy", busy_a, 1);
    op_a[0] = 1'b0;
    idx_a[2:0] = 3'd1;
    tick();
    chk("t2_pulse1_en", en_a, 8'h08);
    chk("t2_pulse1_r", r_a, 8'hF7);
    tick();
    chk("t2_pulse2_en", en_a, 8'h08);
    tick();
    chk("t2_hold_en", en_a, 8'h00);
    chk("t2_hold_r", r_a, 8'hF7);
    tick();
    chk("t2_done_ack", ack_a, 4'b0001);
    chk("t2_done_s", s_a, 8'hFF);
    chk("t2_done_r", r_a, 8'hFF);
    chk("t2_shadow", sh_a, 8'h08);
    req_a = '0;
    tick();
    chk("t2_idle_busy", busy_a, 0);
    chk("t2_ack_once", ack_a, 0);

    // T3 clear from requester 2
    drive_a(2, 1'b0, 3);
    q_a.push_back(sb_t'{4'b0100, 1'b0, 8'h00});
    tick();
    chk("t3_setup_s", s_a, 8'hF7);
    chk("t3_setup_r", r_a, 8'hFF);
    tick();
    chk("t3_pulse_en", en_a, 8'h08);
    repeat (3) tick();
    chk("t3_done_ack", ack_a, 4'b0100);
    chk("t3_shadow", sh_a, 8'h00);
    req_a = '0;
    tick();

    // T4 round-robin from a fresh pointer; requester 0 re-requests right after its ack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_shadow", sh_a, 8'h00);
    drive_a(0, 1'b1, 0);
    drive_a(1, 1'b1, 1);
    drive_a(2, 1'b1, 2);
    drive_a(3, 1'b0, 0);
    q_a.push_back(sb_t'{4'b0001, 1'b0, 8'h01});
    q_a.push_back(sb_t'{4'b0010, 1'b0, 8'h03});
    q_a.push_back(sb_t'{4'b0100, 1'b0, 8'h07});
    q_a.push_back(sb_t'{4'b1000, 1'b0, 8'h06});
    seen = 0;
    rer  = 1'b0;
    for (int c = 0; c < 80 && seen < 5; c++) begin
      tick();
      if (rer) begin
        drive_a(0, 1'b1, 7);
        q_a.push_back(sb_t'{4'b0001, 1'b0, 8'h86});
        rer = 1'b0;
      end
      if (ack_a != 4'b0) begin
        for (int i = 0; i < 4; i++) if (ack_a[i]) got.push_back(i);
        req_a = req_a & ~ack_a;
        seen++;
        if (seen == 1) rer = 1'b1;
      end
    end
    chk("rr_ack_count", seen, 5);
    for (int k = 0; k < 5; k++) begin
      if (k < got.size()) chk("rr_order", got[k], exp_ord[k]);
    end
    req_a = '0;
    tick();

    // T6 reset while latch 5 is pulsed
    drive_a(1, 1'b1, 5);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (en_a[5] === 1'b1) found = 1'b1;
    end
    chk("t6_pulse_seen", found, 1);
    rst   = 1'b1;
    req_a = '0;
    tick();
    chk("t6_s", s_a, 8'hFF);
    chk("t6_r", r_a, 8'hFF);
    chk("t6_en", en_a, 8'h00);
    chk("t6_busy", busy_a, 0);
    chk("t6_ack", ack_a, 0);
    chk("t6_shadow", sh_a, 8'h00);
    rst = 1'b0;
    repeat (8) tick();
    chk("t6_no_late_ack", ack_a, 0);
    chk("sb_empty_a", q_a.size(), 0);
    chk("sb_empty_b", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
